// File: rtl/sram_rr_arbiter.sv
// Round-robin front end sharing one single-port synchronous SRAM between two clients.
// SRAM controls are registered on grant; read data is routed back by a 2-stage tag pipe.
module sram_rr_arbiter #(
  parameter int p_addr_bit = 5,
  parameter int p_data_bit = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [p_addr_bit-1:0] ADDR0,
  input  logic [p_addr_bit-1:0] ADDR1,
  input  logic [p_data_bit-1:0] WDATA0,
  input  logic [p_data_bit-1:0] WDATA1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  RVALID0,
  output logic                  RVALID1,
  output logic [p_data_bit-1:0] RDATA,
  output logic                  SRAM_CEN,
  output logic                  SRAM_WEN,
  output logic [p_addr_bit-1:0] SRAM_A,
  output logic [p_data_bit-1:0] SRAM_D,
  input  logic [p_data_bit-1:0] SRAM_Q
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e                  last_gnt_q, last_gnt_d;
  logic                   gnt0, gnt1;
  logic                   cen_q, cen_d;
  logic                   wen_q, wen_d;
  logic [p_addr_bit-1:0]  a_q, a_d;
  logic [p_data_bit-1:0]  d_q, d_d;
  logic                   rd1_q, rd1_d;
  port_e                  port1_q, port1_d;
  logic                   rd2_q, rd2_d;
  port_e                  port2_q, port2_d;

  // Under contention the port that did not win last time is favoured.
  always_comb begin : arbiter
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RSTN) begin
      if (REQ0 && REQ1) begin
        gnt0 = (last_gnt_q == PORT1);
        gnt1 = (last_gnt_q == PORT0);
      end else begin
        gnt0 = REQ0;
        gnt1 = REQ1;
      end
    end
  end

  always_comb begin : next_state
    last_gnt_d = last_gnt_q;
    cen_d      = 1'b1;
    wen_d      = 1'b1;
    a_d        = a_q;
    d_d        = d_q;
    rd1_d      = 1'b0;
    port1_d    = PORT0;
    rd2_d      = rd1_q;
    port2_d    = port1_q;
    if (gnt0) begin
      last_gnt_d = PORT0;
      cen_d      = 1'b0;
      wen_d      = ~WE0;
      a_d        = ADDR0;
      d_d        = WDATA0;
      rd1_d      = ~WE0;
      port1_d    = PORT0;
    end else if (gnt1) begin
      last_gnt_d = PORT1;
      cen_d      = 1'b0;
      wen_d      = ~WE1;
      a_d        = ADDR1;
      d_d        = WDATA1;
      rd1_d      = ~WE1;
      port1_d    = PORT1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      last_gnt_q <= PORT1;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      a_q        <= '0;
      d_q        <= '0;
      rd1_q      <= 1'b0;
      port1_q    <= PORT0;
      rd2_q      <= 1'b0;
      port2_q    <= PORT0;
    end else begin
      last_gnt_q <= last_gnt_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      a_q        <= a_d;
      d_q        <= d_d;
      rd1_q      <= rd1_d;
      port1_q    <= port1_d;
      rd2_q      <= rd2_d;
      port2_q    <= port2_d;
    end
  end

  // Stage 2 lines up with the SRAM's registered Q, so data passes straight through.
  assign GNT0     = gnt0;
  assign GNT1     = gnt1;
  assign RVALID0  = rd2_q && (port2_q == PORT0);
  assign RVALID1  = rd2_q && (port2_q == PORT1);
  assign RDATA    = SRAM_Q;
  assign SRAM_CEN = cen_q;
  assign SRAM_WEN = wen_q;
  assign SRAM_A   = a_q;
  assign SRAM_D   = d_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: behavioural SRAM, memory scoreboard and return queue,
// directed scenarios plus a long randomized two-port run.
module tb_sram_rr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sram_rr_arbiter #(.p_addr_bit(AW), .p_data_bit(DW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
    .GNT0(gnt0), .GNT1(gnt1), .RVALID0(rvalid0), .RVALID1(rvalid1), .RDATA(rdata),
    .SRAM_CEN(sram_cen), .SRAM_WEN(sram_wen), .SRAM_A(sram_a), .SRAM_D(sram_d),
    .SRAM_Q(sram_q)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM macro: synchronous, active-low CEN/WEN, registered Q, contents survive reset
  logic [DW-1:0] sram_mem [2**AW];
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_wen) sram_mem[sram_a] <= sram_d;
      else           sram_q <= sram_mem[sram_a];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {int due; bit port; logic [DW-1:0] data;} ret_t;
  ret_t          ret_q[$];
  logic [DW-1:0] mdl_mem [2**AW];
  bit            mdl_last, mdl_prev_gnt, mdl_prev_wen;
  logic [AW-1:0] mdl_prev_a;
  logic [DW-1:0] mdl_prev_d;
  bit            exp_g0, exp_g1, exp_rv0, exp_rv1, exp_cen, exp_wen;
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_d, exp_rdata;

  task automatic model_reset();
    ret_q.delete();
    mdl_last     = 1'b1;
    mdl_prev_gnt = 1'b0;
    mdl_prev_wen = 1'b1;
    mdl_prev_a   = '0;
    mdl_prev_d   = '0;
  endtask

  // Called once per cycle at the negedge: predicts this cycle's outputs, then
  // applies this cycle's grant to the memory image in grant order.
  task automatic model_step();
    bit            win0, win1, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_cen   = !mdl_prev_gnt;
    exp_wen   = mdl_prev_wen;
    exp_a     = mdl_prev_a;
    exp_d     = mdl_prev_d;
    exp_rv0   = 1'b0;
    exp_rv1   = 1'b0;
    exp_rdata = 'x;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      exp_rv0   = !ret_q[0].port;
      exp_rv1   = ret_q[0].port;
      exp_rdata = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    win0 = RSTN && req0 && (!req1 || mdl_last);
    win1 = RSTN && req1 && (!req0 || !mdl_last);
    exp_g0 = win0;
    exp_g1 = win1;
    mdl_prev_gnt = win0 || win1;
    if (mdl_prev_gnt) begin
      we = win0 ? we0 : we1;
      a  = win0 ? addr0 : addr1;
      d  = win0 ? wdata0 : wdata1;
      mdl_last     = win1;
      mdl_prev_wen = !we;
      mdl_prev_a   = a;
      mdl_prev_d   = d;
      if (we) mdl_mem[a] = d;
      else    ret_q.push_back('{cyc + 2, win1, mdl_mem[a]});
    end
  endtask

  // ---------------- client queues and cycle log ----------------
  typedef struct {int at; bit we; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
  op_t q0[$], q1[$];

  typedef struct {
    logic r0, r1, g0, g1, rv0, rv1, cen, wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rdata;
    bit   eg0, eg1, erv0, erv1, ecen, ewen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, erdata;
  } rec_t;
  rec_t log_q[$];

  // Presents queue heads (op.at = earliest cycle), holds them until granted, logs every cycle.
  task automatic run_ops(input int max_cycles);
    rec_t r;
    log_q.delete();
    for (int k = 0; k < max_cycles; k++) begin
      req0 = (q0.size() > 0) && (q0[0].at <= k);
      if (req0) begin we0 = q0[0].we; addr0 = q0[0].a; wdata0 = q0[0].d; end
      req1 = (q1.size() > 0) && (q1[0].at <= k);
      if (req1) begin we1 = q1[0].we; addr1 = q1[0].a; wdata1 = q1[0].d; end
      @(negedge CLK);
      model_step();
      r.r0 = req0; r.r1 = req1; r.g0 = gnt0; r.g1 = gnt1;
      r.rv0 = rvalid0; r.rv1 = rvalid1; r.rdata = rdata;
      r.cen = sram_cen; r.wen = sram_wen; r.a = sram_a; r.d = sram_d;
      r.eg0 = exp_g0; r.eg1 = exp_g1; r.erv0 = exp_rv0; r.erv1 = exp_rv1;
      r.erdata = exp_rdata; r.ecen = exp_cen; r.ewen = exp_wen; r.ea = exp_a; r.ed = exp_d;
      log_q.push_back(r);
      if (exp_g0) void'(q0.pop_front());
      if (exp_g1) void'(q1.pop_front());
      @(posedge CLK); #1;
      if (q0.size() == 0 && q1.size() == 0 && ret_q.size() == 0) break;
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 2**AW; i++) q0.push_back('{0, 1'b1, AW'(i), $urandom});
    run_ops(200);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4;
    #1;
    checks++;
    if ({sram_cen, sram_wen} !== 2'b11) begin
      errors++; $display("FAIL reset_cen_wen got=%b%b exp=11", sram_cen, sram_wen);
    end
    checks++;
    if (sram_a !== '0 || sram_d !== '0) begin
      errors++; $display("FAIL reset_a_d got a=%h d=%h exp a=0 d=0", sram_a, sram_d);
    end
    checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid0, rvalid1);
    end
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++; $display("FAIL reset_no_grant got=%b%b exp=00", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    // two reads in flight, then reset while the first one's RVALID is up
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    @(negedge CLK);
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL reset_seq_gnt_a got=%b exp=1", gnt0); end
    @(posedge CLK); #1;
    addr0 = 5'd4;
    @(negedge CLK);
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL reset_seq_gnt_b got=%b exp=1", gnt0); end
    @(posedge CLK); #1;
    req0 = 1'b0;
    checks++;
    if (rvalid0 !== 1'b1) begin errors++; $display("FAIL reset_seq_rvalid got=%b exp=1", rvalid0); end
    #1;
    RSTN = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({rvalid0, rvalid1, sram_cen} !== 3'b001) begin
      errors++; $display("FAIL reset_midread got rv=%b%b cen=%b exp rv=00 cen=1", rvalid0, rvalid1, sram_cen);
    end
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++;
      if ({rvalid0, rvalid1, sram_cen} !== 3'b001) begin
        errors++; $display("FAIL reset_no_late_rvalid k=%0d got rv=%b%b cen=%b exp rv=00 cen=1", k, rvalid0, rvalid1, sram_cen);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_single_port();
    q0.push_back('{0, 1'b1, 5'd3, 32'hDEADBEEF});
    q0.push_back('{0, 1'b0, 5'd3, 32'h0});
    run_ops(20);
    foreach (log_q[i]) begin
      checks++;
      if ({log_q[i].g0, log_q[i].g1} !== {log_q[i].eg0, log_q[i].eg1}) begin
        errors++; $display("FAIL single_gnt k=%0d got=%b%b exp=%b%b", i, log_q[i].g0, log_q[i].g1, log_q[i].eg0, log_q[i].eg1);
      end
      checks++;
      if ({log_q[i].rv0, log_q[i].rv1} !== {log_q[i].erv0, log_q[i].erv1}) begin
        errors++; $display("FAIL single_rvalid k=%0d got=%b%b exp=%b%b", i, log_q[i].rv0, log_q[i].rv1, log_q[i].erv0, log_q[i].erv1);
      end
    end
    checks++;
    if (log_q[0].g0 !== 1'b1 || log_q[1].g0 !== 1'b1) begin
      errors++; $display("FAIL single_gnt_each_cycle got=%b%b exp=11", log_q[0].g0, log_q[1].g0);
    end
    checks++;
    if (log_q[2].rv0 !== 1'b0 || log_q[3].rv0 !== 1'b1) begin
      errors++; $display("FAIL single_latency got k2=%b k3=%b exp k2=0 k3=1", log_q[2].rv0, log_q[3].rv0);
    end
    checks++;
    if (log_q[3].rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_rdata got=%h exp=deadbeef", log_q[3].rdata);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      q0.push_back('{0, 1'b0, AW'(i), 32'h0});
      q1.push_back('{0, 1'b0, AW'(16 + i), 32'h0});
    end
    run_ops(40);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({log_q[k].g0, log_q[k].g1} !== {k % 2 == 0, k % 2 == 1}) begin
        errors++; $display("FAIL contention_alternate k=%0d got=%b%b exp=%b%b", k, log_q[k].g0, log_q[k].g1, k % 2 == 0, k % 2 == 1);
      end
    end
    foreach (log_q[i]) begin
      checks++;
      if ({log_q[i].rv0, log_q[i].rv1} !== {log_q[i].erv0, log_q[i].erv1}) begin
        errors++; $display("FAIL contention_rvalid k=%0d got=%b%b exp=%b%b", i, log_q[i].rv0, log_q[i].rv1, log_q[i].erv0, log_q[i].erv1);
      end
      if (log_q[i].erv0 || log_q[i].erv1) begin
        checks++;
        if (log_q[i].rdata !== log_q[i].erdata) begin
          errors++; $display("FAIL contention_rdata k=%0d got=%h exp=%h", i, log_q[i].rdata, log_q[i].erdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    q1.push_back('{0, 1'b1, 5'd31, 32'h1});
    q0.push_back('{1, 1'b0, 5'd31, 32'h0});
    q0.push_back('{2, 1'b0, 5'd0, 32'h0});
    run_ops(20);
    checks++;
    if (log_q[0].g1 !== 1'b1 || log_q[1].g0 !== 1'b1) begin
      errors++; $display("FAIL b2b_grants got g1@0=%b g0@1=%b exp 1 1", log_q[0].g1, log_q[1].g0);
    end
    checks++;
    if (log_q[3].rv0 !== 1'b1 || log_q[3].rdata !== 32'h1) begin
      errors++; $display("FAIL b2b_raw got rv=%b rdata=%h exp rv=1 rdata=00000001", log_q[3].rv0, log_q[3].rdata);
    end
    checks++;
    if (log_q[4].rv0 !== 1'b1 || log_q[4].rdata !== log_q[4].erdata) begin
      errors++; $display("FAIL b2b_addr0 got rv=%b rdata=%h exp rv=1 rdata=%h", log_q[4].rv0, log_q[4].rdata, log_q[4].erdata);
    end
  endtask

  task automatic test_read_before_write();
    q1.push_back('{0, 1'b1, 5'd5, 32'hA});
    q1.push_back('{2, 1'b1, 5'd5, 32'hB});
    q0.push_back('{2, 1'b0, 5'd5, 32'h0});
    q0.push_back('{4, 1'b0, 5'd5, 32'h0});
    run_ops(20);
    checks++;
    if ({log_q[2].g0, log_q[2].g1, log_q[3].g1} !== 3'b101) begin
      errors++; $display("FAIL rbw_grants got=%b%b%b exp=101", log_q[2].g0, log_q[2].g1, log_q[3].g1);
    end
    checks++;
    if (log_q[4].rv0 !== 1'b1 || log_q[4].rdata !== 32'hA) begin
      errors++; $display("FAIL rbw_old_data got rv=%b rdata=%h exp rv=1 rdata=0000000a", log_q[4].rv0, log_q[4].rdata);
    end
    checks++;
    if (log_q[6].rv0 !== 1'b1 || log_q[6].rdata !== 32'hB) begin
      errors++; $display("FAIL rbw_new_data got rv=%b rdata=%h exp rv=1 rdata=0000000b", log_q[6].rv0, log_q[6].rdata);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, 2**AW - 1));
  endfunction

  task automatic test_random();
    int at0 = 0;
    int at1 = 0;
    int wait0 = 0;
    int wait1 = 0;
    for (int i = 0; i < 5000; i++) begin
      at0 += $urandom_range(0, 3);
      at1 += $urandom_range(0, 3);
      q0.push_back('{at0, 1'($urandom_range(0, 1)), rand_addr(), $urandom});
      q1.push_back('{at1, 1'($urandom_range(0, 1)), rand_addr(), $urandom});
    end
    run_ops(30000);
    foreach (log_q[i]) begin
      checks++;
      if ({log_q[i].g0, log_q[i].g1} !== {log_q[i].eg0, log_q[i].eg1}) begin
        errors++; $display("FAIL rand_gnt k=%0d got=%b%b exp=%b%b", i, log_q[i].g0, log_q[i].g1, log_q[i].eg0, log_q[i].eg1);
      end
      checks++;
      if (log_q[i].g0 === 1'b1 && log_q[i].g1 === 1'b1) begin
        errors++; $display("FAIL rand_onehot k=%0d got=11 exp=not both", i);
      end
      checks++;
      if ({log_q[i].rv0, log_q[i].rv1} !== {log_q[i].erv0, log_q[i].erv1}) begin
        errors++; $display("FAIL rand_rvalid k=%0d got=%b%b exp=%b%b", i, log_q[i].rv0, log_q[i].rv1, log_q[i].erv0, log_q[i].erv1);
      end
      if (log_q[i].erv0 || log_q[i].erv1) begin
        checks++;
        if (log_q[i].rdata !== log_q[i].erdata) begin
          errors++; $display("FAIL rand_rdata k=%0d got=%h exp=%h", i, log_q[i].rdata, log_q[i].erdata);
        end
      end
      checks++;
      if (log_q[i].cen !== log_q[i].ecen) begin
        errors++; $display("FAIL rand_cen k=%0d got=%b exp=%b", i, log_q[i].cen, log_q[i].ecen);
      end
      if (!log_q[i].ecen) begin
        checks++;
        if (log_q[i].a !== log_q[i].ea || log_q[i].wen !== log_q[i].ewen) begin
          errors++; $display("FAIL rand_issue k=%0d got a=%h wen=%b exp a=%h wen=%b", i, log_q[i].a, log_q[i].wen, log_q[i].ea, log_q[i].ewen);
        end
        if (!log_q[i].ewen) begin
          checks++;
          if (log_q[i].d !== log_q[i].ed) begin
            errors++; $display("FAIL rand_wdata k=%0d got=%h exp=%h", i, log_q[i].d, log_q[i].ed);
          end
        end
      end
      wait0 = (log_q[i].r0 && log_q[i].g0 !== 1'b1) ? wait0 + 1 : 0;
      wait1 = (log_q[i].r1 && log_q[i].g1 !== 1'b1) ? wait1 + 1 : 0;
      if (log_q[i].r0 || log_q[i].r1) begin
        checks++;
        if (wait0 > 1 || wait1 > 1) begin
          errors++; $display("FAIL rand_fairness k=%0d got wait0=%0d wait1=%0d exp <=1", i, wait0, wait1);
        end
      end
    end
  endtask

  initial begin
    RSTN = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    test_reset();
    preload();
    test_single_port();
    test_contention();
    test_back_to_back();
    test_read_before_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
